// File: rtl/window_accum.sv
// Collects WIN consecutive accepted results into one window and presents the
// registered window sum and all-zero flag downstream through a valid/ready handshake.
module window_accum #(
    parameter int DW  = 4,
    parameter int WIN = 4,
    parameter int SW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [SW-1:0] out_sum,
    output logic          out_zero,
    input  logic          out_ready
);

    localparam int CW = (WIN <= 2) ? 1 : $clog2(WIN);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_acc;
    logic          r_zacc;
    logic          r_out_valid;
    logic [SW-1:0] r_out_sum;
    logic          r_out_zero;

    logic          w_in_ready;
    logic          w_accept;
    logic [SW-1:0] w_data_ext;
    logic          w_in_zero;

    function automatic logic is_zero(input logic [DW-1:0] d);
        return (d == {DW{1'b0}});
    endfunction

    // In HOLD the sink's ready is passed straight through so a transfer and a new beat share one cycle.
    assign w_in_ready = ~rst & ((r_state == ST_ACCUM) | out_ready);
    assign w_accept   = in_valid & w_in_ready;
    assign w_data_ext = {{(SW-DW){1'b0}}, in_data};
    assign w_in_zero  = is_zero(in_data);

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_zero  = r_out_zero;

    // Window FSM: accumulates beats, latches the completed window, waits for the sink.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_cnt       <= {CW{1'b0}};
            r_acc       <= {SW{1'b0}};
            r_zacc      <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= {SW{1'b0}};
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (r_cnt == CNT_LAST) begin
                            r_out_sum   <= r_acc + w_data_ext;
                            r_out_zero  <= r_zacc & w_in_zero;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_HOLD;
                            r_acc       <= {SW{1'b0}};
                            r_zacc      <= 1'b1;
                            r_cnt       <= {CW{1'b0}};
                        end else begin
                            r_acc  <= r_acc + w_data_ext;
                            r_zacc <= r_zacc & w_in_zero;
                            r_cnt  <= r_cnt + CW'(1);
                        end
                    end else begin
                        r_state <= ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_ACCUM;
                        // WIN >= 2, so this beat can never complete a window on its own.
                        if (w_accept) begin
                            r_acc  <= w_data_ext;
                            r_zacc <= w_in_zero;
                            r_cnt  <= CW'(1);
                        end else begin
                            r_cnt  <= {CW{1'b0}};
                        end
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_accum.sv
// Directed bench for window_accum: a table of per-cycle vectors with hand-computed
// expectations, plus a hand-written back-to-back streaming sequence.
module tb_window_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic       out_zero;
    logic       out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    window_accum #(.DW(4), .WIN(4), .SW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_zero  (out_zero),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] d;
        logic       ordy;
        logic       e_ir;    // in_ready before the edge
        logic       e_ov;    // out_valid after the edge
        logic [7:0] e_sum;   // out_sum after the edge (when chk)
        logic       e_zero;  // out_zero after the edge (when chk)
        logic       chk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [3:0] d, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [7:0] e_sum,
                       input logic e_zero, input logic chk);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy; v.e_ir = e_ir;
        v.e_ov = e_ov; v.e_sum = e_sum; v.e_zero = e_zero; v.chk = chk;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset
        add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1);
        add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1);
        // basic window 1,2,3,4
        add(1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 8'd10, 1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd10, 1'b0, 1'b1);
        // zero flag: 0,0,0,0
        add(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 8'd0,  1'b1, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b1, 1'b1);
        // 0,0,1,0 -> not zero, sum 1; outputs keep value after transfer
        add(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 8'd1,  1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd1,  1'b0, 1'b1);
        // stall: window 1,1,2,2 = 6 with sink not ready
        add(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 8'd6,  1'b0, 1'b1);
        add(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 8'd6,  1'b0, 1'b1);
        add(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 8'd6,  1'b0, 1'b1);
        add(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 8'd6,  1'b0, 1'b1);
        // release: transfer and beat 5 becomes beat 0 of next window
        add(1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 8'd6,  1'b0, 1'b1);
        add(1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 8'd11, 1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd11, 1'b0, 1'b1);
        // reset mid-window after 2 beats, then 4 beats of 2
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1);
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 8'd8,  1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd8,  1'b0, 1'b1);
        // reset while holding a window
        add(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 8'd4,  1'b0, 1'b1);
        add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1);
        // gapped input: 3, idle, idle, 3, idle, 3, 3
        add(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 8'd12, 1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd12, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            #1;
            check("in_ready", i, {7'd0, in_ready}, {7'd0, vecs[i].e_ir});
            @(posedge clk);
            #1;
            check("out_valid", i, {7'd0, out_valid}, {7'd0, vecs[i].e_ov});
            if (vecs[i].chk) begin
                check("out_sum", i, out_sum, vecs[i].e_sum);
                check("out_zero", i, {7'd0, out_zero}, {7'd0, vecs[i].e_zero});
            end
        end

        // streaming: 8 back-to-back beats of 15 with the sink always ready
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = 4'd15;
            #1;
            check("stream_in_ready", k, {7'd0, in_ready}, 8'd1);
            @(posedge clk);
            #1;
            if (k == 3 || k == 7) begin
                check("stream_out_valid", k, {7'd0, out_valid}, 8'd1);
                check("stream_out_sum", k, out_sum, 8'd60);
            end else begin
                check("stream_out_valid", k, {7'd0, out_valid}, 8'd0);
            end
        end
        in_valid = 1'b0;
        #1;
        check("stream_tail_in_ready", 8, {7'd0, in_ready}, 8'd1);
        @(posedge clk);
        #1;
        check("stream_tail_out_valid", 8, {7'd0, out_valid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
